pos_equiv_checker: RTL and testbench
====================================

// Module: pos_equiv_checker
// PURPOSE
//  Sequential exhaustive checker for an N-input Boolean function given in canonical
//  product-of-sums (maxterm) form. After start, it walks all 2^N input rows. For each
//  row it drives the row to an external candidate implementation (e.g. a simplified
//  form) and compares the candidate's output with the canonical PoS value. It reports
//  equivalence, the mismatch count and the first failing row. Sits beside combinational
//  logic-minimisation blocks as their self-check engine.
// PARAMETERS
//  N    3   number of function inputs (1..8); rows = 2^N
//  CW   N+1 width of mismatch counter (derived localparam, holds 0..2^N)
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  start       in   1      pulse: begin a sweep (sampled only in IDLE)
//  abort       in   1      cancel a running sweep (sampled only in RUN)
//  maxterms    in   2^N    bit i=1 -> maxterm M_i present (function is 0 at row i)
//  cand        in   1      candidate function output for current vec (combinational)
//  vec         out  N      current row; vec[N-1] = MSB input (X), vec[0] = LSB (Z)
//  ref_out     out  1      canonical PoS value at vec = ~mask_q[vec]
//  busy        out  1      high while in RUN
//  done        out  1      one-cycle pulse at end of a complete sweep
//  equal       out  1      1 = last completed sweep had zero mismatches
//  mism_count  out  CW     number of mismatching rows in current/last sweep
//  first_mism  out  N      lowest row index that mismatched
//  first_valid out  1      first_mism holds a valid row
// BEHAVIOUR
//  States: IDLE -> RUN -> DONE -> IDLE.
//  Reset (async, any state): state=IDLE, mask_q=0, vec=0, busy=0, done=0, equal=0,
//   mism_count=0, first_mism=0, first_valid=0. ref_out=1 follows from mask_q=0.
//  IDLE + start=1: mask_q<=maxterms, vec<=0, mism_count<=0, first_valid<=0,
//   first_mism<=0, equal<=0, ->RUN.
//  maxterms is latched only on that edge. Later changes do not affect the sweep.
//  RUN, each edge: compare cand with ref_out for the current vec.
//   - On mismatch: mism_count++. If first_valid=0, first_mism<=vec and first_valid<=1.
//   - If vec==2^N-1: ->DONE. Otherwise vec<=vec+1.
//   - vec never wraps inside a sweep.
//  RUN + abort=1: ->IDLE and discard the current row compare. done is not pulsed.
//   equal stays 0. Counters hold their partial values.
//  start while in RUN or DONE is ignored.
//  DONE (one cycle): done=1, equal=(mism_count==0), busy=0, ->IDLE.
//   equal, mism_count and first_* hold until the next start or reset.
//  Latency: done is high during cycle 2^N+1 after the start edge (N=3 -> 9 cycles).
//  Moore outputs: busy = (state==RUN), done = (state==DONE).
//  ref_out is combinational from registers: valid in every state and glitch-free
//   relative to vec.
//  cand must settle within the same cycle as vec. It is sampled on the next rising edge.
// TESTING (N=3 unless stated; bench models cand combinationally from vec)
//  1 maxterms=8'b1100_0100 (M2,M6,M7), cand=~vec[1]|(vec[0]&~vec[2]); pulse start
//    -> done at cycle 9, equal=1, mism_count=0, first_valid=0.
//  2 Same maxterms, cand=1 -> equal=0, mism_count=3, first_mism=2, first_valid=1.
//  3 Assert reset at cycle 4 of a sweep -> all outputs return to reset values
//    immediately, without waiting for a clock edge. A new start runs a full 8-row sweep.
//  4 Pulse start again at cycle 3, then change maxterms at cycle 5
//    -> no restart, result uses the latched mask. Then abort at cycle 6 -> IDLE, no done.
//  5 N=4, maxterms=16'hFFFF, cand=0 -> done at cycle 17, equal=1, mism_count=0.
//  6 maxterms=0, cand=vec[0] -> mism_count=4, first_mism=0.
//    Back-to-back start the cycle after done -> second sweep gives the same result.

Source files
------------

// File: rtl/pos_equiv_checker.sv
// rtl/pos_equiv_checker.sv - exhaustive equivalence checker for a PoS (maxterm) function
//
// Purpose: after start, sweeps all 2^N input rows, drives each row on vec,
//   compares the external candidate output (cand) against the canonical
//   product-of-sums value and reports mismatch count, first failing row and
//   overall equivalence.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   start, abort      - begin a sweep (IDLE only) / cancel a sweep (RUN only)
//   maxterms [2^N]    - bit i set means the function is 0 at row i
//   cand              - candidate output for the current vec
//   vec [N]           - current row (vec[N-1] is the MSB input)
//   ref_out           - canonical PoS value at vec
//   busy, done        - sweep in progress / one-cycle end-of-sweep pulse
//   equal             - last completed sweep had no mismatches
//   mism_count [CW]   - mismatching rows in current/last sweep
//   first_mism [N]    - lowest mismatching row, qualified by first_valid

module pos_equiv_checker #(
  parameter  int N    = 3,
  localparam int ROWS = 1 << N,
  localparam int CW   = N + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [ROWS-1:0] maxterms,
  input  logic            cand,
  output logic [N-1:0]    vec,
  output logic            ref_out,
  output logic            busy,
  output logic            done,
  output logic            equal,
  output logic [CW-1:0]   mism_count,
  output logic [N-1:0]    first_mism,
  output logic            first_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [ROWS-1:0] mask_q;
  logic            mismatch;
  logic            last_row;

  // Canonical PoS: the function is 0 exactly at the rows whose maxterm is present.
  assign ref_out  = ~mask_q[vec];
  assign mismatch = cand ^ ref_out;
  assign last_row = &vec;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (abort) begin
          next_state = IDLE;
        end else if (last_row) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q      <= '0;
      vec         <= '0;
      equal       <= 1'b0;
      mism_count  <= '0;
      first_mism  <= '0;
      first_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_q      <= maxterms;
            vec         <= '0;
            equal       <= 1'b0;
            mism_count  <= '0;
            first_mism  <= '0;
            first_valid <= 1'b0;
          end
        end
        RUN: begin
          // Abort drops the compare of the row currently on vec.
          if (!abort) begin
            if (mismatch) begin
              mism_count <= mism_count + CW'(1);
              if (!first_valid) begin
                first_mism  <= vec;
                first_valid <= 1'b1;
              end
            end
            // equal is resolved on the last row's edge so it is already valid
            // while done is high; it must include the last row's own compare.
            if (last_row) begin
              equal <= (mism_count == '0) && !mismatch;
            end else begin
              vec <= vec + N'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_equiv_checker.sv
// tb/tb_pos_equiv_checker.sv - directed self-checking bench for pos_equiv_checker

module tb_pos_equiv_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  maxterms;
  logic        cand;
  logic [2:0]  vec;
  logic        ref_out;
  logic        busy;
  logic        done;
  logic        equal;
  logic [3:0]  mism_count;
  logic [2:0]  first_mism;
  logic        first_valid;

  logic        start4;
  logic [15:0] maxterms4;
  logic        cand4;
  logic [3:0]  vec4;
  logic        ref_out4;
  logic        busy4;
  logic        done4;
  logic        equal4;
  logic [4:0]  mism_count4;
  logic [3:0]  first_mism4;
  logic        first_valid4;

  int mode;
  int checks   = 0;
  int failures = 0;
  int lat;
  int seen_done;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       cand = ~vec[1] | (vec[0] & ~vec[2]);
      2:       cand = 1'b1;
      3:       cand = vec[0];
      default: cand = 1'b0;
    endcase
  end

  assign cand4 = 1'b0;

  pos_equiv_checker #(.N(3)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .maxterms(maxterms), .cand(cand), .vec(vec), .ref_out(ref_out),
    .busy(busy), .done(done), .equal(equal), .mism_count(mism_count),
    .first_mism(first_mism), .first_valid(first_valid)
  );

  pos_equiv_checker #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(1'b0),
    .maxterms(maxterms4), .cand(cand4), .vec(vec4), .ref_out(ref_out4),
    .busy(busy4), .done(done4), .equal(equal4), .mism_count(mism_count4),
    .first_mism(first_mism4), .first_valid(first_valid4)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle (1 = first cycle after the start edge) in which done is seen.
  task automatic run_sweep(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start4 = 1'b0; abort = 1'b0;
    maxterms = 8'h00; maxterms4 = 16'h0000; mode = 0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_equal", int'(equal), 0);
    chk("rst_mism", int'(mism_count), 0);
    chk("rst_first", int'(first_mism), 0);
    chk("rst_fvalid", int'(first_valid), 0);
    chk("rst_vec", int'(vec), 0);
    chk("rst_ref", int'(ref_out), 1);
    tick();
    reset = 1'b0;
    tick();

    // 1: equivalent simplified form of M2,M6,M7
    maxterms = 8'hC4; mode = 1;
    run_sweep(lat);
    chk("t1_latency", lat, 9);
    chk("t1_equal", int'(equal), 1);
    chk("t1_mism", int'(mism_count), 0);
    chk("t1_fvalid", int'(first_valid), 0);
    chk("t1_busy_in_done", int'(busy), 0);
    tick();
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_equal_hold", int'(equal), 1);

    // 2: constant-1 candidate disagrees at rows 2,6,7
    mode = 2;
    run_sweep(lat);
    chk("t2_latency", lat, 9);
    chk("t2_equal", int'(equal), 0);
    chk("t2_mism", int'(mism_count), 3);
    chk("t2_first", int'(first_mism), 2);
    chk("t2_fvalid", int'(first_valid), 1);
    tick();

    // 3: asynchronous reset mid-sweep
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t3_pre_vec", int'(vec), 3);
    chk("t3_pre_mism", int'(mism_count), 1);
    reset = 1'b1;
    #1;
    chk("t3_busy", int'(busy), 0);
    chk("t3_vec", int'(vec), 0);
    chk("t3_mism", int'(mism_count), 0);
    chk("t3_fvalid", int'(first_valid), 0);
    chk("t3_ref", int'(ref_out), 1);
    tick();
    reset = 1'b0;
    tick();
    run_sweep(lat);
    chk("t3_latency", lat, 9);
    chk("t3_mism_after", int'(mism_count), 3);
    tick();

    // 4: ignored restart, latched mask, abort
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t4_no_restart_vec", int'(vec), 4);
    chk("t4_busy", int'(busy), 1);
    maxterms = 8'hFF;
    #1;
    chk("t4_latched_ref", int'(ref_out), 1);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_abort_busy", int'(busy), 0);
    chk("t4_abort_mism", int'(mism_count), 1);
    chk("t4_abort_first", int'(first_mism), 2);
    chk("t4_abort_equal", int'(equal), 0);
    chk("t4_abort_vec", int'(vec), 5);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done = 1;
      tick();
    end
    chk("t4_no_done", seen_done, 0);

    // 5: N=4, all maxterms present, constant-0 candidate
    maxterms4 = 16'hFFFF;
    start4 = 1'b1; tick(); start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 60) begin
      tick();
      lat++;
    end
    chk("t5_latency", lat, 17);
    chk("t5_equal", int'(equal4), 1);
    chk("t5_mism", int'(mism_count4), 0);
    tick();

    // 6: constant-1 function vs vec[0], then back-to-back sweep
    maxterms = 8'h00; mode = 3;
    run_sweep(lat);
    chk("t6_latency", lat, 9);
    chk("t6_mism", int'(mism_count), 4);
    chk("t6_first", int'(first_mism), 0);
    chk("t6_fvalid", int'(first_valid), 1);
    tick();
    chk("t6_hold_mism", int'(mism_count), 4);
    chk("t6_done_low", int'(done), 0);
    run_sweep(lat);
    chk("t6b_latency", lat, 9);
    chk("t6b_mism", int'(mism_count), 4);
    chk("t6b_first", int'(first_mism), 0);
    chk("t6b_equal", int'(equal), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
